// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch unit: branch condition encodings
// and the flush counter width.
package pc_branch_unit_pkg;

  // branch_cond encodings; 3'b010 and 3'b011 are reserved (never taken)
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;

  // Flush counter holds FLUSH_CYCLES in the range 1..7
  localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_branch_unit_branch_cond_eval.sv
// Combinational branch condition evaluator: maps a condition select and
// the ULA flags to a single "condition holds" bit.
module branch_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       zero,
  input  logic       less,
  input  logic       less_u,
  output logic       cond_true
);

  // Decode the selected condition; reserved encodings are never true
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      BR_EQ:   cond_true = zero;
      BR_NE:   cond_true = ~zero;
      BR_LT:   cond_true = less;
      BR_GE:   cond_true = ~less;
      BR_LTU:  cond_true = less_u;
      BR_GEU:  cond_true = ~less_u;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and redirect unit: selects the next PC among sequential,
// branch, jump and register targets, raises a multi-cycle flush after a
// taken redirect and keeps a saturating taken-redirect counter.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned           WIDTH        = 32,
  parameter logic [WIDTH-1:0]      RESET_PC     = '0,
  parameter int unsigned           PC_INC       = 1,
  parameter int unsigned           FLUSH_CYCLES = 1,
  parameter int unsigned           CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch,
  input  logic [2:0]           branch_cond,
  input  logic                 jump,
  input  logic                 jump_reg,
  input  logic                 zero,
  input  logic                 less,
  input  logic                 less_u,
  input  logic [WIDTH-1:0]     imm_target,
  input  logic [WIDTH-1:0]     jump_target,
  input  logic [WIDTH-1:0]     reg_target,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_seq,
  output logic                 taken,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt_next;
  logic                   shadow;
  logic                   cond_true;
  logic [WIDTH-1:0]       target;

  assign pc_seq = pc + WIDTH'(PC_INC);

  branch_cond_eval u_cond_eval (
    .cond      (branch_cond),
    .zero      (zero),
    .less      (less),
    .less_u    (less_u),
    .cond_true (cond_true)
  );

  // Redirect decision and target select; instructions in the flush shadow are ignored
  always_comb begin
    shadow = (flush_cnt != '0);
    taken  = ~stall & ~shadow & (jump_reg | jump | (branch & cond_true));
    target = imm_target;
    if (jump_reg)  target = reg_target;
    else if (jump) target = jump_target;
  end

  // Flush counter next value: load on taken, count down on unstalled cycles
  always_comb begin
    flush_cnt_next = flush_cnt;
    if (taken)                         flush_cnt_next = FLUSH_LOAD;
    else if (shadow && !stall)         flush_cnt_next = flush_cnt - 1'b1;
  end

  // Program counter register
  always_ff @(posedge clk) begin
    if (reset)       pc <= RESET_PC;
    else if (!stall) pc <= taken ? target : pc_seq;
  end

  // Flush counter and registered flush; flush tracks the counter being nonzero
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
      flush     <= 1'b0;
    end else begin
      flush_cnt <= flush_cnt_next;
      flush     <= (flush_cnt_next != '0);
    end
  end

  // Saturating count of taken redirects
  always_ff @(posedge clk) begin
    if (reset)                              taken_count <= '0;
    else if (taken && (taken_count != '1))  taken_count <= taken_count + 1'b1;
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: two configurations share one
// stimulus stream; a reference model pushes expected outputs per cycle and
// a monitor pops and compares them on the falling edge.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jump_reg, zero, less, less_u;
  logic [2:0]  branch_cond;
  logic [15:0] it, jt, rt;

  logic [15:0] pc_a, seq_a, cnt_a;
  logic        tk_a, fl_a;
  logic [7:0]  pc_b, seq_b;
  logic [1:0]  cnt_b;
  logic        tk_b, fl_b;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .WIDTH(16), .RESET_PC(16'h0000), .PC_INC(1), .FLUSH_CYCLES(1), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_cond(branch_cond),
    .jump(jump), .jump_reg(jump_reg), .zero(zero), .less(less), .less_u(less_u),
    .imm_target(it), .jump_target(jt), .reg_target(rt),
    .pc(pc_a), .pc_seq(seq_a), .taken(tk_a), .flush(fl_a), .taken_count(cnt_a)
  );

  pc_branch_unit #(
    .WIDTH(8), .RESET_PC(8'h10), .PC_INC(1), .FLUSH_CYCLES(3), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_cond(branch_cond),
    .jump(jump), .jump_reg(jump_reg), .zero(zero), .less(less), .less_u(less_u),
    .imm_target(it[7:0]), .jump_target(jt[7:0]), .reg_target(rt[7:0]),
    .pc(pc_b), .pc_seq(seq_b), .taken(tk_b), .flush(fl_b), .taken_count(cnt_b)
  );

  typedef struct packed {
    logic [1:0][15:0] pc;
    logic [1:0][15:0] seq;
    logic [1:0]       tk;
    logic [1:0]       fl;
    logic [1:0][15:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // per-configuration parameters
  int unsigned p_w[2]    = '{16, 8};
  int unsigned p_rpc[2]  = '{0, 16};
  int unsigned p_inc[2]  = '{1, 1};
  int unsigned p_fc[2]   = '{1, 3};
  int unsigned p_cw[2]   = '{16, 2};

  // model state: PC, remaining unstalled flush cycles, redirect count
  longint unsigned m_pc[2];
  longint unsigned m_fl[2];
  longint unsigned m_cnt[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]  = p_rpc[k];
      m_fl[k]  = 0;
      m_cnt[k] = 0;
    end
  endtask

  // Drive one cycle of inputs, push the expected outputs, then advance the model
  task automatic cyc(input bit rst, input bit st, input bit br, input logic [2:0] cd,
                     input bit jp, input bit jr, input bit z, input bit l, input bit lu,
                     input logic [15:0] t_imm, input logic [15:0] t_jmp, input logic [15:0] t_reg);
    exp_t e;
    logic [7:0] tbl;
    @(posedge clk);
    #1;
    reset = rst; stall = st; branch = br; branch_cond = cd; jump = jp; jump_reg = jr;
    zero = z; less = l; less_u = lu; it = t_imm; jt = t_jmp; rt = t_reg;
    tbl = {~lu, lu, ~l, l, 2'b00, ~z, z};
    e = '0;
    for (int k = 0; k < 2; k++) begin
      longint unsigned msk  = (64'd1 << p_w[k]) - 1;
      longint unsigned cmax = (64'd1 << p_cw[k]) - 1;
      longint unsigned tgt;
      bit want, tk;
      want = jr || jp || (br && tbl[cd]);
      tk   = !st && (m_fl[k] == 0) && want;
      tgt  = jr ? t_reg : (jp ? t_jmp : t_imm);
      tgt  = tgt & msk;
      e.pc[k]  = 16'(m_pc[k]);
      e.seq[k] = 16'((m_pc[k] + p_inc[k]) & msk);
      e.tk[k]  = tk;
      e.fl[k]  = (m_fl[k] != 0);
      e.cnt[k] = 16'(m_cnt[k]);
      if (rst) begin
        m_pc[k] = p_rpc[k]; m_fl[k] = 0; m_cnt[k] = 0;
      end else begin
        if (!st) m_pc[k] = tk ? tgt : ((m_pc[k] + p_inc[k]) & msk);
        if (tk) m_fl[k] = p_fc[k];
        else if (m_fl[k] != 0 && !st) m_fl[k] = m_fl[k] - 1;
        if (tk && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0);
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_a",    {48'd0, pc_a},        {48'd0, e.pc[0]});
        chk("pcseq_a", {48'd0, seq_a},       {48'd0, e.seq[0]});
        chk("taken_a", {63'd0, tk_a},        {63'd0, e.tk[0]});
        chk("flush_a", {63'd0, fl_a},        {63'd0, e.fl[0]});
        chk("count_a", {48'd0, cnt_a},       {48'd0, e.cnt[0]});
        chk("pc_b",    {56'd0, pc_b},        {48'd0, e.pc[1]});
        chk("pcseq_b", {56'd0, seq_b},       {48'd0, e.seq[1]});
        chk("taken_b", {63'd0, tk_b},        {63'd0, e.tk[1]});
        chk("flush_b", {63'd0, fl_b},        {63'd0, e.fl[1]});
        chk("count_b", {62'd0, cnt_b},       {48'd0, e.cnt[1]});
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 0; branch = 0; branch_cond = 0; jump = 0; jump_reg = 0;
    zero = 0; less = 0; less_u = 0; it = 0; jt = 0; rt = 0;
    @(posedge clk);
    #1;
    model_reset();

    // reset state, then sequential run
    cyc(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0);
    idle(5);
    // taken beq, then not-taken beq
    cyc(0, 0, 1, 3'b000, 0, 0, 1, 0, 0, 16'd40, 16'd0, 16'd0);
    idle(4);
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 16'd40, 16'd0, 16'd0);
    idle(2);
    // priority, then a jump in the shadow
    cyc(0, 0, 1, 3'b000, 1, 1, 1, 0, 0, 16'd300, 16'd200, 16'd100);
    cyc(0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0, 16'd7, 16'd0);
    idle(4);
    // stall beats a pending jump, then the jump goes through
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'd0, 1, 0, 0, 0, 0, 16'd0, 16'd50, 16'd0);
    cyc(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 16'd0, 16'd50, 16'd0);
    idle(4);
    // stall inside the flush window
    cyc(0, 0, 1, 3'b100, 0, 0, 0, 1, 0, 16'd20, 16'd0, 16'd0);
    idle(1);
    cyc(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0);
    idle(4);
    // reset during flush
    cyc(0, 0, 1, 3'b111, 0, 0, 0, 0, 0, 16'd60, 16'd0, 16'd0);
    idle(1);
    cyc(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0);
    idle(2);
    // reserved conditions never taken
    cyc(0, 0, 1, 3'b010, 0, 0, 1, 1, 1, 16'd77, 16'd0, 16'd0);
    cyc(0, 0, 1, 3'b011, 0, 0, 0, 0, 0, 16'd77, 16'd0, 16'd0);
    cyc(0, 0, 1, 3'b010, 0, 0, 0, 0, 0, 16'd77, 16'd0, 16'd0);
    // PC wrap at all-ones
    cyc(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 16'd0, 16'hFFFD, 16'd0);
    idle(6);
    // counter saturation (narrow config saturates at 3)
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 16'd0, 16'(i * 9), 16'd0);
      idle(4);
    end
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
          3'($urandom_range(7)), ($urandom_range(5) == 0), ($urandom_range(7) == 0),
          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          16'($urandom), 16'($urandom), 16'($urandom));
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
